// File: rtl/armleosoc_axi_read_router.sv
// AXI4 read router: decodes AR address against a region table, rebases it, forwards to one client and
// muxes the R channel back; one outstanding burst at a time; unmapped addresses get a local DECERR burst.
module armleosoc_axi_read_router #(
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int OPT_NUMBER_OF_CLIENTS = 2,
  parameter int REGION_COUNT = OPT_NUMBER_OF_CLIENTS,
  localparam int CLIENT_W = (OPT_NUMBER_OF_CLIENTS > 1) ? $clog2(OPT_NUMBER_OF_CLIENTS) : 1,
  parameter logic [REGION_COUNT*CLIENT_W-1:0] REGION_CLIENT_NUM = '0,
  parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_BASE_ADDRS = '0,
  parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_END_ADDRS = '0,
  parameter logic [REGION_COUNT*ADDR_WIDTH-1:0] REGION_CLIENT_BASE_ADDRS = '0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,

  input  logic                                    upstream_axi_arvalid,
  output logic                                    upstream_axi_arready,
  input  logic [ADDR_WIDTH-1:0]                   upstream_axi_araddr,
  input  logic [7:0]                              upstream_axi_arlen,
  input  logic [2:0]                              upstream_axi_arsize,
  input  logic [1:0]                              upstream_axi_arburst,
  input  logic                                    upstream_axi_arlock,
  input  logic [ID_WIDTH-1:0]                     upstream_axi_arid,
  input  logic [2:0]                              upstream_axi_arprot,

  output logic                                    upstream_axi_rvalid,
  input  logic                                    upstream_axi_rready,
  output logic [DATA_WIDTH-1:0]                   upstream_axi_rdata,
  output logic [1:0]                              upstream_axi_rresp,
  output logic [ID_WIDTH-1:0]                     upstream_axi_rid,
  output logic                                    upstream_axi_rlast,

  output logic [OPT_NUMBER_OF_CLIENTS-1:0]        downstream_axi_arvalid,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]        downstream_axi_arready,
  output logic [ADDR_WIDTH-1:0]                   downstream_axi_araddr,
  output logic [7:0]                              downstream_axi_arlen,
  output logic [2:0]                              downstream_axi_arsize,
  output logic [1:0]                              downstream_axi_arburst,
  output logic                                    downstream_axi_arlock,
  output logic [2:0]                              downstream_axi_arprot,
  output logic [ID_WIDTH-1:0]                     downstream_axi_arid,

  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]        downstream_axi_rvalid,
  output logic [OPT_NUMBER_OF_CLIENTS-1:0]        downstream_axi_rready,
  input  logic [OPT_NUMBER_OF_CLIENTS*DATA_WIDTH-1:0] downstream_axi_rdata,
  input  logic [OPT_NUMBER_OF_CLIENTS*2-1:0]      downstream_axi_rresp,
  input  logic [OPT_NUMBER_OF_CLIENTS*ID_WIDTH-1:0] downstream_axi_rid,
  input  logic [OPT_NUMBER_OF_CLIENTS-1:0]        downstream_axi_rlast
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DECERR} state_t;

  state_t                state, state_d;
  logic                  ardone, ardone_d;
  logic [CLIENT_W-1:0]   sel, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt, cnt_d;

  logic                  hit;
  logic [CLIENT_W-1:0]   hit_client;
  logic [ADDR_WIDTH-1:0] hit_base;

  // Later regions overwrite earlier ones, so the highest-index match wins.
  always_comb begin
    hit = 1'b0;
    hit_client = '0;
    hit_base = '0;
    for (int r = 0; r < REGION_COUNT; r++) begin
      if (upstream_axi_araddr >= REGION_BASE_ADDRS[r*ADDR_WIDTH +: ADDR_WIDTH] &&
          upstream_axi_araddr <  REGION_END_ADDRS[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        hit_client = REGION_CLIENT_NUM[r*CLIENT_W +: CLIENT_W];
        hit_base = REGION_CLIENT_BASE_ADDRS[r*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign downstream_axi_araddr  = addr_q;
  assign downstream_axi_arlen   = upstream_axi_arlen;
  assign downstream_axi_arsize  = upstream_axi_arsize;
  assign downstream_axi_arburst = upstream_axi_arburst;
  assign downstream_axi_arlock  = upstream_axi_arlock;
  assign downstream_axi_arprot  = upstream_axi_arprot;
  assign downstream_axi_arid    = upstream_axi_arid;

  always_comb begin
    state_d = state;
    ardone_d = ardone;
    sel_d = sel;
    addr_d = addr_q;
    id_d = id_q;
    len_d = len_q;
    cnt_d = cnt;
    upstream_axi_arready = 1'b0;
    upstream_axi_rvalid = 1'b0;
    upstream_axi_rdata = '0;
    upstream_axi_rresp = 2'b00;
    upstream_axi_rid = '0;
    upstream_axi_rlast = 1'b0;
    downstream_axi_arvalid = '0;
    downstream_axi_rready = '0;

    case (state)
      IDLE: begin
        if (upstream_axi_arvalid) begin
          if (hit) begin
            sel_d = hit_client;
            addr_d = upstream_axi_araddr - hit_base;
            ardone_d = 1'b0;
            state_d = ACTIVE;
          end else begin
            upstream_axi_arready = 1'b1;
            id_d = upstream_axi_arid;
            len_d = upstream_axi_arlen;
            cnt_d = 8'd0;
            state_d = DECERR;
          end
        end
      end
      ACTIVE: begin
        for (int c = 0; c < OPT_NUMBER_OF_CLIENTS; c++) begin
          if (CLIENT_W'(c) == sel) begin
            downstream_axi_arvalid[c] = upstream_axi_arvalid & ~ardone;
            upstream_axi_arready = downstream_axi_arready[c] & ~ardone;
            // R path stays gated until the address has actually been handed off.
            if (ardone) begin
              upstream_axi_rvalid = downstream_axi_rvalid[c];
              upstream_axi_rdata = downstream_axi_rdata[c*DATA_WIDTH +: DATA_WIDTH];
              upstream_axi_rresp = downstream_axi_rresp[c*2 +: 2];
              upstream_axi_rid = downstream_axi_rid[c*ID_WIDTH +: ID_WIDTH];
              upstream_axi_rlast = downstream_axi_rlast[c];
              downstream_axi_rready[c] = upstream_axi_rready;
            end
          end
        end
        if (upstream_axi_arvalid && upstream_axi_arready)
          ardone_d = 1'b1;
        if (upstream_axi_rvalid && upstream_axi_rready && upstream_axi_rlast) begin
          ardone_d = 1'b0;
          state_d = IDLE;
        end
      end
      DECERR: begin
        upstream_axi_rvalid = 1'b1;
        upstream_axi_rresp = 2'b11;
        upstream_axi_rid = id_q;
        upstream_axi_rlast = (cnt == len_q);
        if (upstream_axi_rready) begin
          cnt_d = cnt + 8'd1;
          if (upstream_axi_rlast)
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The miss path drives arready combinationally from IDLE; keep it quiet while held in reset.
    if (!rst_n)
      upstream_axi_arready = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ardone <= 1'b0;
      sel <= '0;
      addr_q <= '0;
      id_q <= '0;
      len_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      ardone <= ardone_d;
      sel <= sel_d;
      addr_q <= addr_d;
      id_q <= id_d;
      len_q <= len_d;
      cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_armleosoc_axi_read_router.sv
// Directed bench for armleosoc_axi_read_router: transaction-level model with per-cycle compare plus literal checks.
module tb_armleosoc_axi_read_router;

  localparam logic [33:0] RB  [2] = '{34'h0000, 34'h1000};
  localparam logic [33:0] RE  [2] = '{34'h1000, 34'h2000};
  localparam logic [33:0] RCB [2] = '{34'h0000, 34'h1000};
  localparam int          RC  [2] = '{0, 1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        up_arvalid, up_arready, up_arlock;
  logic [33:0] up_araddr;
  logic [7:0]  up_arlen;
  logic [2:0]  up_arsize, up_arprot;
  logic [1:0]  up_arburst;
  logic [3:0]  up_arid;
  logic        up_rvalid, up_rready, up_rlast;
  logic [31:0] up_rdata;
  logic [1:0]  up_rresp;
  logic [3:0]  up_rid;
  logic [1:0]  ds_arvalid, ds_arready;
  logic [33:0] ds_araddr;
  logic [7:0]  ds_arlen;
  logic [2:0]  ds_arsize, ds_arprot;
  logic [1:0]  ds_arburst;
  logic        ds_arlock;
  logic [3:0]  ds_arid;
  logic [1:0]  ds_rvalid, ds_rready, ds_rlast;
  logic [63:0] ds_rdata;
  logic [3:0]  ds_rresp;
  logic [7:0]  ds_rid;

  armleosoc_axi_read_router #(
    .ADDR_WIDTH(34), .ID_WIDTH(4), .DATA_WIDTH(32), .OPT_NUMBER_OF_CLIENTS(2), .REGION_COUNT(2),
    .REGION_CLIENT_NUM(2'b10),
    .REGION_BASE_ADDRS({34'h1000, 34'h0000}),
    .REGION_END_ADDRS({34'h2000, 34'h1000}),
    .REGION_CLIENT_BASE_ADDRS({34'h1000, 34'h0000})
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .upstream_axi_arvalid(up_arvalid), .upstream_axi_arready(up_arready),
    .upstream_axi_araddr(up_araddr), .upstream_axi_arlen(up_arlen), .upstream_axi_arsize(up_arsize),
    .upstream_axi_arburst(up_arburst), .upstream_axi_arlock(up_arlock), .upstream_axi_arid(up_arid),
    .upstream_axi_arprot(up_arprot),
    .upstream_axi_rvalid(up_rvalid), .upstream_axi_rready(up_rready), .upstream_axi_rdata(up_rdata),
    .upstream_axi_rresp(up_rresp), .upstream_axi_rid(up_rid), .upstream_axi_rlast(up_rlast),
    .downstream_axi_arvalid(ds_arvalid), .downstream_axi_arready(ds_arready),
    .downstream_axi_araddr(ds_araddr), .downstream_axi_arlen(ds_arlen), .downstream_axi_arsize(ds_arsize),
    .downstream_axi_arburst(ds_arburst), .downstream_axi_arlock(ds_arlock), .downstream_axi_arprot(ds_arprot),
    .downstream_axi_arid(ds_arid),
    .downstream_axi_rvalid(ds_rvalid), .downstream_axi_rready(ds_rready), .downstream_axi_rdata(ds_rdata),
    .downstream_axi_rresp(ds_rresp), .downstream_axi_rid(ds_rid), .downstream_axi_rlast(ds_rlast)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic [3:0]  id;
    logic        l;
  } beat_t;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Address map model: highest-index matching region wins.
  function automatic void decode(input logic [33:0] a, output bit hit, output int cl, output logic [33:0] ra);
    hit = 1'b0; cl = 0; ra = a;
    for (int r = 1; r >= 0; r--) begin
      if (!hit && a >= RB[r] && a < RE[r]) begin
        hit = 1'b1; cl = RC[r]; ra = a - RCB[r];
      end
    end
  endfunction

  function automatic logic [31:0] bdata(input int c, input logic [33:0] ra, input int i);
    return {c[3:0], ra[19:0], i[7:0]};
  endfunction

  function automatic logic [1:0] cresp(input int c);
    return (c == 1) ? 2'b01 : 2'b00;
  endfunction

  // Client emulators: accept every AR, then stream len+1 beats back-to-back.
  beat_t cq0[$];
  beat_t cq1[$];
  initial begin
    logic [1:0] ar_hs, r_hs;
    logic [33:0] a;
    logic [7:0] len;
    logic [3:0] id;
    logic rs;
    ds_arready = 2'b11;
    ds_rvalid = 2'b00; ds_rdata = '0; ds_rresp = '0; ds_rid = '0; ds_rlast = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs = ds_arvalid & ds_arready; r_hs = ds_rvalid & ds_rready;
      a = ds_araddr; len = ds_arlen; id = ds_arid; rs = rst_n;
      @(posedge clk); #1;
      if (!rs || !rst_n) begin
        cq0.delete(); cq1.delete();
      end else begin
        if (r_hs[0]) void'(cq0.pop_front());
        if (r_hs[1]) void'(cq1.pop_front());
        for (int i = 0; i <= int'(len); i++) begin
          if (ar_hs[0]) cq0.push_back('{bdata(0, a, i), cresp(0), id, i == int'(len)});
          if (ar_hs[1]) cq1.push_back('{bdata(1, a, i), cresp(1), id, i == int'(len)});
        end
      end
      ds_rvalid[0] = cq0.size() != 0;
      ds_rvalid[1] = cq1.size() != 0;
      if (cq0.size() != 0) {ds_rdata[31:0], ds_rresp[1:0], ds_rid[3:0], ds_rlast[0]} = cq0[0];
      if (cq1.size() != 0) {ds_rdata[63:32], ds_rresp[3:2], ds_rid[7:4], ds_rlast[1]} = cq1[0];
    end
  end

  // Model + per-cycle compare.
  beat_t exp_q[$];
  int burst_beats = 0, rlast_at = 0, ds_ar_count = 0;
  logic [1:0] last_ds_arvalid;
  logic [33:0] last_ds_araddr;
  beat_t last_beat;
  initial begin
    bit hit;
    int cl;
    logic [33:0] ra;
    logic [1:0] oh;
    beat_t cur, held, e;
    bit held_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); held_vld = 1'b0; burst_beats = 0;
        continue;
      end
      chk("ready_valid_shape", {61'd0, (ds_rready & ~{2{up_rready}}) != 0,
          $countones(ds_rready) > 1, $countones(ds_arvalid) > 1}, 64'd0);
      if (ds_arvalid != 2'b00) begin
        decode(up_araddr, hit, cl, ra);
        oh = 2'b00;
        if (hit && up_arvalid) oh[cl] = 1'b1;
        chk("ds_ar_route", {16'd0, ds_arvalid, ds_araddr, ds_arid, ds_arlen},
            {16'd0, oh, ra, up_arid, up_arlen});
        last_ds_arvalid = ds_arvalid; last_ds_araddr = ds_araddr;
        if ((ds_arvalid & ds_arready) != 2'b00) ds_ar_count++;
      end
      if (up_arvalid && up_arready) begin
        chk("ar_while_busy", 64'(exp_q.size()), 64'd0);
        decode(up_araddr, hit, cl, ra);
        chk("ar_ds_forwarded", {63'd0, ds_arvalid != 2'b00}, {63'd0, hit});
        burst_beats = 0;
        for (int i = 0; i <= int'(up_arlen); i++) begin
          if (hit) exp_q.push_back('{bdata(cl, ra, i), cresp(cl), up_arid, i == int'(up_arlen)});
          else     exp_q.push_back('{32'd0, 2'b11, up_arid, i == int'(up_arlen)});
        end
      end
      cur = '{up_rdata, up_rresp, up_rid, up_rlast};
      if (held_vld) chk("r_hold_stable", {24'd0, up_rvalid, cur}, {24'd0, 1'b1, held});
      held_vld = 1'b0;
      if (up_rvalid) begin
        if (up_rready) begin
          if (exp_q.size() == 0) begin
            chk("r_unexpected_beat", {25'd0, cur}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("r_beat", {25'd0, cur}, {25'd0, e});
          end
          burst_beats++;
          last_beat = cur;
          if (up_rlast) rlast_at = burst_beats;
        end else begin
          held_vld = 1'b1; held = cur;
        end
      end
    end
  end

  // Drivers, always entered just after a rising edge.
  task automatic do_ar(input logic [33:0] addr, input logic [3:0] id, input logic [7:0] len, output int lat);
    bit hs;
    up_arvalid = 1'b1; up_araddr = addr; up_arid = id; up_arlen = len;
    lat = 0;
    forever begin
      @(negedge clk);
      hs = up_arready;
      @(posedge clk); #1;
      if (hs) break;
      lat++;
      if (lat > 200) begin fail_now("ar_handshake_timeout"); break; end
    end
    up_arvalid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin @(posedge clk); #1; k++; end
    if (k >= 300) fail_now("burst_done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (burst_beats < n && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) fail_now("beat_wait_timeout");
  endtask

  initial begin
    int lat, arc;
    rst_n = 1'b0;
    up_arvalid = 1'b1; up_araddr = 34'h3000; up_arid = 4'd0; up_arlen = 8'd0;
    up_arsize = 3'd2; up_arburst = 2'b01; up_arlock = 1'b0; up_arprot = 3'd0; up_rready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {58'd0, up_arready, up_rvalid, ds_arvalid, ds_rready}, 64'd0);
    up_arvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_ar(34'h1010, 4'd3, 8'd3, lat);
    chk("hit_ar_latency", 64'(lat), 64'd1);
    chk("hit_ds_arvalid", 64'(last_ds_arvalid), 64'h2);
    chk("hit_ds_araddr", 64'(last_ds_araddr), 64'h010);
    wait_done();
    chk("hit_beats", 64'(burst_beats), 64'd4);
    chk("hit_rlast_at", 64'(rlast_at), 64'd4);
    chk("hit_last_beat", {25'd0, last_beat}, {25'd0, 32'h10001003, 2'b01, 4'd3, 1'b1});

    arc = ds_ar_count;
    do_ar(34'h3000, 4'd5, 8'd2, lat);
    chk("miss_ar_latency", 64'(lat), 64'd0);
    wait_done();
    chk("miss_no_ds_ar", 64'(ds_ar_count), 64'(arc));
    chk("miss_beats", 64'(burst_beats), 64'd3);
    chk("miss_rlast_at", 64'(rlast_at), 64'd3);
    chk("miss_last_beat", {25'd0, last_beat}, {25'd0, 32'd0, 2'b11, 4'd5, 1'b1});

    do_ar(34'h3000, 4'd9, 8'd0, lat);
    wait_done();
    chk("miss_len0_beats", 64'(burst_beats), 64'd1);
    chk("miss_len0_rlast_at", 64'(rlast_at), 64'd1);

    do_ar(34'h0FFF, 4'd1, 8'd0, lat);
    chk("b0fff_route", {28'd0, last_ds_arvalid, last_ds_araddr}, {28'd0, 2'b01, 34'h0FFF});
    wait_done();
    chk("b0fff_last_beat", {25'd0, last_beat}, {25'd0, 32'h00000FFF >> 0 << 8, 2'b00, 4'd1, 1'b1});
    do_ar(34'h1000, 4'd2, 8'd0, lat);
    chk("b1000_route", {28'd0, last_ds_arvalid, last_ds_araddr}, {28'd0, 2'b10, 34'h0});
    wait_done();
    do_ar(34'h2000, 4'd4, 8'd0, lat);
    chk("b2000_decerr_latency", 64'(lat), 64'd0);
    wait_done();
    chk("b2000_rresp", 64'(last_beat.r), 64'd3);

    do_ar(34'h1020, 4'd6, 8'd3, lat);
    wait_beats(2);
    up_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {61'd0, ds_rready[1], up_rvalid, up_rready}, {61'd0, 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    up_rready = 1'b1;
    wait_done();
    chk("bp_beats", 64'(burst_beats), 64'd4);
    chk("bp_last_beat", {25'd0, last_beat}, {25'd0, 32'h10002003, 2'b01, 4'd6, 1'b1});

    do_ar(34'h1010, 4'd7, 8'd3, lat);
    wait_beats(1);
    #1 rst_n = 1'b0;
    #1 chk("midburst_reset_outputs", {58'd0, up_arready, up_rvalid, ds_arvalid, ds_rready}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_ar(34'h0004, 4'd1, 8'd1, lat);
    chk("post_reset_route", {28'd0, last_ds_arvalid, last_ds_araddr}, {28'd0, 2'b01, 34'h4});
    wait_done();
    chk("post_reset_beats", 64'(burst_beats), 64'd2);

    do_ar(34'h1010, 4'd8, 8'd3, lat);
    do_ar(34'h0004, 4'd2, 8'd0, lat);
    chk("b2b_second_ar_wait", 64'(lat), 64'd5);
    chk("b2b_route", {28'd0, last_ds_arvalid, last_ds_araddr}, {28'd0, 2'b01, 34'h4});
    wait_done();
    chk("b2b_last_beat", {25'd0, last_beat}, {25'd0, 32'h00000400, 2'b00, 4'd2, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
